tns_dec_arbiter: RTL
====================

// Module: tns_dec_arbiter
// PURPOSE
//  Shares one TNS_dec_15 decoder (15-bit 5-stage TNS codeword -> `BLEN05-bit binary) among N
//  receive TSV bundles. Round-robin grant, registered codeword, registered decode result.
//  Valid/ready on both sides. Sits between the per-bundle RX capture registers and the
//  data sink.
// PARAMETERS
//  N     4   number of requesters, 2..8
//  SRC_W 2   source-index width, $clog2(N)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   N          requester i offers a codeword
//  req_code   in   N*15       codeword i in bits [15*i+14:15*i]
//  req_ready  out  N          one-hot, combinational; grant/accept pulse for requester i
//  out_valid  out  1          out_data/out_src valid
//  out_ready  in   1          sink accepts
//  out_data   out  `BLEN05    decoded value
//  out_src    out  SRC_W      index of the requester that supplied the codeword
//  out_err    out  1          illegal-codeword flag; present only with TNS_CHECK_EN
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, out_valid=0, out_data=0, out_src=0, out_err=0, ptr=N-1.
//   Reset mid-operation drops the in-flight codeword. No partial output appears.
//  FSM states:
//   IDLE: if |req_valid, grant g = first set req_valid at or after ptr+1 (mod N).
//     req_ready[g]=1 this cycle. code_q<=req_code[g]. src_q<=g. ptr<=g. Go to DEC.
//   DEC: out_data<=dec(code_q), out_src<=src_q. Go to OUT.
//   OUT: out_valid=1. On out_ready: if |req_valid, grant as in IDLE in the same cycle and
//     go to DEC (back-to-back). Otherwise go to IDLE.
//  req_ready is asserted only in IDLE, or in OUT while out_ready=1. It is never asserted
//   for a requester with req_valid=0.
//  Latency: accept cycle T -> out_valid at T+2. Peak throughput: 1 codeword per 2 cycles.
//  Requesters hold req_valid and req_code stable until their req_ready. Dropping valid
//   early is allowed and costs no grant.
//  out_valid && !out_ready: out_data, out_src and out_err stay stable. No new grant occurs.
//  Round robin: ptr wraps N-1 -> 0. After reset, requester 0 has top priority.
//   A single active requester is granted every slot.
//  Arithmetic: dec() is the TNS_dec_15 sum of weighted bits, width `BLEN05, no truncation.
//   Bit 14 maps to `TNS05_A and bit 0 maps to `TNS01_C.
// CONFIGURATION
//  TNS_CHECK_EN defined:
//   In DEC, out_err<=1 if any 3-bit group code_q[3k+2:3k] equals 3'b010 or 3'b101
//    (forbidden 3C pattern). out_data is still the decoded value.
//   out_err follows the same reset, hold and valid timing as out_data.
//  TNS_CHECK_EN undefined: out_err port and the check logic are absent.
// STRUCTURE
//  Shared header TNS.vh: `BLEN05 and `TNS0x_{A,B,C} weights, plus new macro `TNS_CW_W=15.
//  Local: state encoding localparams IDLE/DEC/OUT.
//  One sub-module: a TNS_dec_15 instance on code_q. Its output is registered in DEC.
//  Arbiter, pointer and FSM are inline.
// TESTING
//  1 Reset: rst high during traffic -> all outputs 0 and ptr=N-1 next edge. First grant
//    after release goes to req 0 when all valid.
//  2 Single request: req 2, code 15'h0001, out_ready=1 -> req_ready=4'b0100 at T.
//    At T+2: out_valid=1, out_data=`TNS01_C, out_src=2.
//  3 All 4 valid and held, out_ready=1 -> grants in order 0,1,2,3,0 every 2 cycles.
//    out_src follows the same order.
//  4 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> outputs stable and
//    req_ready=0 throughout. Raise out_ready -> next grant in the same cycle.
//  5 Decode sweep: codes 15'h0000, 15'h4000, 15'h7FFF -> out_data = 0, `TNS05_A, and the
//    sum of all fifteen weights.
//  6 TNS_CHECK_EN: code 15'h0005 -> out_err=1. Code 15'h0007 -> out_err=0.
//    Build without the macro compiles with no out_err port.

Source files
------------

// File: rtl/tns_dec_arbiter_pkg.sv
// Shared definitions for the TNS_dec_15 decoder arbiter: codeword and result
// widths, the per-bit TNS weights, the arbiter FSM state type and a weight
// lookup used by the decoder.
//
// Each 3-bit stage k (k = 1..5) carries weights A, B and C with A = 3*C and
// B = 2*C, and C = 7^(k-1). A stage therefore encodes a digit 0..6, and the
// largest codeword value is 7^5 - 1 = 16806, which fits in BLEN05 bits.
package tns_dec_arbiter_pkg;

  localparam int TNS_CW_W = 15;
  localparam int BLEN05   = 15;

  localparam logic [BLEN05-1:0] TNS01_C = 15'd1;
  localparam logic [BLEN05-1:0] TNS01_B = 15'd2;
  localparam logic [BLEN05-1:0] TNS01_A = 15'd3;
  localparam logic [BLEN05-1:0] TNS02_C = 15'd7;
  localparam logic [BLEN05-1:0] TNS02_B = 15'd14;
  localparam logic [BLEN05-1:0] TNS02_A = 15'd21;
  localparam logic [BLEN05-1:0] TNS03_C = 15'd49;
  localparam logic [BLEN05-1:0] TNS03_B = 15'd98;
  localparam logic [BLEN05-1:0] TNS03_A = 15'd147;
  localparam logic [BLEN05-1:0] TNS04_C = 15'd343;
  localparam logic [BLEN05-1:0] TNS04_B = 15'd686;
  localparam logic [BLEN05-1:0] TNS04_A = 15'd1029;
  localparam logic [BLEN05-1:0] TNS05_C = 15'd2401;
  localparam logic [BLEN05-1:0] TNS05_B = 15'd4802;
  localparam logic [BLEN05-1:0] TNS05_A = 15'd7203;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Weight of codeword bit idx; bit 0 is stage-1 C, bit 14 is stage-5 A.
  function automatic logic [BLEN05-1:0] tns_weight(input int idx);
    case (idx)
      0:       return TNS01_C;
      1:       return TNS01_B;
      2:       return TNS01_A;
      3:       return TNS02_C;
      4:       return TNS02_B;
      5:       return TNS02_A;
      6:       return TNS03_C;
      7:       return TNS03_B;
      8:       return TNS03_A;
      9:       return TNS04_C;
      10:      return TNS04_B;
      11:      return TNS04_A;
      12:      return TNS05_C;
      13:      return TNS05_B;
      14:      return TNS05_A;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/tns_dec_arbiter_dec.sv
// TNS_dec_15: purely combinational 15-bit, 5-stage TNS codeword decoder.
// The result is the sum of the weights of all set codeword bits, computed at
// full BLEN05 width.
// Optional feature macro: TNS_CHECK_EN adds the err output, which flags any
// stage holding the forbidden 3C patterns 3'b010 or 3'b101.
module tns_dec_arbiter_dec
  import tns_dec_arbiter_pkg::*;
(
  input  logic [TNS_CW_W-1:0] code,
  output logic [BLEN05-1:0]   value
`ifdef TNS_CHECK_EN
  ,
  output logic                err
`endif
);

  // Weighted-bit sum of the codeword.
  always_comb begin
    value = '0;
    for (int i = 0; i < TNS_CW_W; i++) begin
      if (code[i]) begin
        value = value + tns_weight(i);
      end
    end
  end

`ifdef TNS_CHECK_EN
  // Any stage holding an alternating pattern is not a legal 3C code.
  always_comb begin
    err = 1'b0;
    for (int k = 0; k < TNS_CW_W / 3; k++) begin
      if ((code[3*k +: 3] == 3'b010) || (code[3*k +: 3] == 3'b101)) begin
        err = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/tns_dec_arbiter.sv
// tns_dec_arbiter: shares one TNS_dec_15 decoder among N receive TSV bundles.
// Round-robin grant, registered codeword, registered decode result, with
// valid/ready handshakes towards both the requesters and the sink.
// Optional feature macro: TNS_CHECK_EN adds the out_err illegal-codeword flag.
//
// Timing: a codeword accepted in cycle T is decoded in T+1 and presented with
// out_valid in T+2. A new grant can be issued in the same cycle the sink takes
// the current result, giving one codeword per two cycles at best.
module tns_dec_arbiter
  import tns_dec_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int SRC_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*TNS_CW_W-1:0] req_code,
  output logic [N-1:0]          req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLEN05-1:0]     out_data,
  output logic [SRC_W-1:0]      out_src
`ifdef TNS_CHECK_EN
  ,
  output logic                  out_err
`endif
);

  localparam logic [SRC_W-1:0] PTR_RESET = SRC_W'(N - 1);
  localparam logic [N-1:0]     ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                next_state;
  logic [SRC_W-1:0]      ptr;
  logic [SRC_W-1:0]      cand;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  grant_slot;
  logic                  grant;
  logic [TNS_CW_W-1:0]   sel_code;
  logic [TNS_CW_W-1:0]   code_q;
  logic [SRC_W-1:0]      src_q;
  logic [BLEN05-1:0]     dec_value;
`ifdef TNS_CHECK_EN
  logic                  dec_err;
`endif

  // Round-robin search: first valid requester at or after ptr+1, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = SRC_W'((int'(ptr) + off) % N);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A grant slot exists when idle or when the sink is taking the current result.
  always_comb begin
    grant_slot = !rst && ((state == IDLE) || ((state == OUT) && out_ready));
    grant      = grant_slot && grant_any;
    req_ready  = grant ? (ONE_HOT0 << grant_idx) : '0;
  end

  // Codeword of the requester being granted this cycle.
  always_comb begin
    sel_code = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_code = req_code[i*TNS_CW_W +: TNS_CW_W];
      end
    end
  end

  // Next-state logic: IDLE -> DEC on grant, DEC -> OUT, OUT drains or chains.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant) begin
          next_state = DEC;
        end
      end
      DEC: begin
        next_state = OUT;
      end
      OUT: begin
        if (out_ready) begin
          next_state = grant ? DEC : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign out_valid = (state == OUT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  tns_dec_arbiter_dec dec_u (
    .code  (code_q),
    .value (dec_value)
`ifdef TNS_CHECK_EN
    ,
    .err   (dec_err)
`endif
  );

  // Capture the granted codeword and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= PTR_RESET;
      code_q <= '0;
      src_q  <= '0;
    end else if (grant) begin
      ptr    <= grant_idx;
      code_q <= sel_code;
      src_q  <= grant_idx;
    end
  end

  // Register the decode result in DEC; it is held unchanged through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
`ifdef TNS_CHECK_EN
      out_err  <= 1'b0;
`endif
    end else if (state == DEC) begin
      out_data <= dec_value;
      out_src  <= src_q;
`ifdef TNS_CHECK_EN
      out_err  <= dec_err;
`endif
    end
  end

endmodule
